// File: rtl/axi_arb_pkg.sv
// Shared types and field widths for the round-robin AXI read arbiter.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ADDR,
        ARB_DATA
    } arb_state_t;

    localparam int AXI_LEN_W  = 8;
    localparam int AXI_RESP_W = 2;

endpackage

// File: rtl/axi_rr_pick.sv
// Round-robin picker: first asserted request found scanning from ptr upward, modulo N.
module axi_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    function automatic int wrap(input int v);
        return (v >= N) ? v - N : v;
    endfunction

    logic [N-1:0] rotated;

    // Rotate so the pointer lands at bit 0, priority-encode, then map back.
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rotated = '0;
        valid   = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (j == wrap(int'(ptr) + k)) rotated[k] = req[j];
            end
        end
        valid = |rotated;
        for (int k = N - 1; k >= 0; k--) begin
            if (rotated[k]) idx = IDX_W'(wrap(int'(ptr) + k));
        end
    end

endmodule

// File: rtl/axi_read_arbiter_rr.sv
// N-master to 1-slave AXI read arbiter: round-robin AR grant, grant held until the R burst's last beat.
module axi_read_arbiter_rr
    import axi_arb_pkg::*;
#(
    parameter int  N_MST  = 4,
    parameter int  ADDR_W = 32,
    parameter int  DATA_W = 32,
    localparam int IDX_W  = (N_MST > 1) ? $clog2(N_MST) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_MST-1:0]            s_arvalid,
    output logic [N_MST-1:0]            s_arready,
    input  logic [N_MST*ADDR_W-1:0]     s_araddr,
    input  logic [N_MST*AXI_LEN_W-1:0]  s_arlen,
    output logic                        m_arvalid,
    input  logic                        m_arready,
    output logic [ADDR_W-1:0]           m_araddr,
    output logic [AXI_LEN_W-1:0]        m_arlen,
    input  logic                        m_rvalid,
    output logic                        m_rready,
    input  logic [DATA_W-1:0]           m_rdata,
    input  logic [AXI_RESP_W-1:0]       m_rresp,
    input  logic                        m_rlast,
    output logic [N_MST-1:0]            s_rvalid,
    input  logic [N_MST-1:0]            s_rready,
    output logic [DATA_W-1:0]           s_rdata,
    output logic [AXI_RESP_W-1:0]       s_rresp,
    output logic                        s_rlast,
    output logic [IDX_W-1:0]            grant_idx,
    output logic                        busy
);

    arb_state_t             state;
    logic [IDX_W-1:0]       rr_ptr;
    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;
    logic [IDX_W-1:0]       next_ptr;
    logic                   sel_arvalid;
    logic                   sel_rready;
    logic [ADDR_W-1:0]      sel_addr;
    logic [AXI_LEN_W-1:0]   sel_len;

    axi_rr_pick #(
        .N     (N_MST),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (s_arvalid),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Pointer moves to the master after the one just served, wrapping at N_MST-1.
    assign next_ptr = (grant_idx == IDX_W'(N_MST - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        sel_arvalid = 1'b0;
        sel_rready  = 1'b0;
        sel_addr    = '0;
        sel_len     = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (i == int'(grant_idx)) begin
                sel_arvalid = s_arvalid[i];
                sel_rready  = s_rready[i];
                sel_addr    = s_araddr[i*ADDR_W +: ADDR_W];
                sel_len     = s_arlen[i*AXI_LEN_W +: AXI_LEN_W];
            end
        end
    end

    // Handshakes are gated by state so nothing leaks out while IDLE; grant_idx is registered,
    // so there is no path from s_arvalid to m_arvalid in IDLE.
    always_comb begin
        m_arvalid = (state == ARB_ADDR) && sel_arvalid;
        m_rready  = (state == ARB_DATA) && sel_rready;
        s_arready = '0;
        s_rvalid  = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (i == int'(grant_idx)) begin
                s_arready[i] = (state == ARB_ADDR) && m_arready;
                s_rvalid[i]  = (state == ARB_DATA) && m_rvalid;
            end
        end
    end

    assign m_araddr = sel_addr;
    assign m_arlen  = sel_len;
    assign s_rdata  = m_rdata;
    assign s_rresp  = m_rresp;
    assign s_rlast  = m_rlast;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: reset is synchronous; it only takes effect on a clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        grant_idx <= pick_idx;
                        state     <= ARB_ADDR;
                        busy      <= 1'b1;
                    end
                end
                ARB_ADDR: begin
                    // Grant is held even if the master withdraws arvalid.
                    if (m_arvalid && m_arready) state <= ARB_DATA;
                end
                ARB_DATA: begin
                    if (m_rvalid && m_rready && m_rlast) begin
                        state  <= ARB_IDLE;
                        busy   <= 1'b0;
                        rr_ptr <= next_ptr;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
